// File: rtl/scr1_ahb_arb2.sv
// Two-master AHB-Lite arbiter: M0 (data bridge) and M1 (instruction bridge) share one system-bus port.
// Latency: zero added cycles; address, control and ready pass through combinationally.
// Backpressure: a losing master sees mX_hready=0 and holds its request; a finished data phase for a
//   refused master is parked in a per-master hold register and delivered when its next address is taken.
// Ports: clk/rst_n; m0_*/m1_* face the two bridges (htrans..hwdata in, hready/hrdata/hresp out);
//   s_* is the shared master port (address/control/wdata out, hready/hrdata/hresp in).
module scr1_ahb_arb2 #(
  parameter int unsigned ARB_FIXED = 0,
  parameter int unsigned AHB_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  // master 0 (data)
  input  logic [1:0]       m0_htrans,
  input  logic [AHB_W-1:0] m0_haddr,
  input  logic             m0_hwrite,
  input  logic [2:0]       m0_hsize,
  input  logic [3:0]       m0_hprot,
  input  logic [2:0]       m0_hburst,
  input  logic [AHB_W-1:0] m0_hwdata,
  output logic             m0_hready,
  output logic [AHB_W-1:0] m0_hrdata,
  output logic             m0_hresp,
  // master 1 (instruction)
  input  logic [1:0]       m1_htrans,
  input  logic [AHB_W-1:0] m1_haddr,
  input  logic             m1_hwrite,
  input  logic [2:0]       m1_hsize,
  input  logic [3:0]       m1_hprot,
  input  logic [2:0]       m1_hburst,
  input  logic [AHB_W-1:0] m1_hwdata,
  output logic             m1_hready,
  output logic [AHB_W-1:0] m1_hrdata,
  output logic             m1_hresp,
  // shared bus
  output logic [1:0]       s_htrans,
  output logic [AHB_W-1:0] s_haddr,
  output logic             s_hwrite,
  output logic [2:0]       s_hsize,
  output logic [3:0]       s_hprot,
  output logic [2:0]       s_hburst,
  output logic [AHB_W-1:0] s_hwdata,
  input  logic             s_hready,
  input  logic [AHB_W-1:0] s_hrdata,
  input  logic             s_hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [1:0]            req;
  logic                  grant_comb, grant, gnt_req, addr_acc, sel_m1;
  logic                  lock_q, lock_d, gnt_q;
  logic                  last_q, last_d;
  logic                  dvalid_q, dvalid_d, downer_q, downer_d;
  logic [1:0]            hold_v_q, hold_v_d;
  logic [1:0][AHB_W-1:0] hold_rdata_q, hold_rdata_d;
  logic [1:0]            hold_resp_q, hold_resp_d;
  logic [1:0]            dph, bus_done, aok, hready;

  assign req[0] = (m0_htrans == HTRANS_NONSEQ);
  assign req[1] = (m1_htrans == HTRANS_NONSEQ);

  // With no request the grant parks on M0, so idle address outputs come from M0.
  always_comb begin
    grant_comb = 1'b0;
    if (req[1] && !req[0]) begin
      grant_comb = 1'b1;
    end else if (req[0] && req[1]) begin
      grant_comb = (ARB_FIXED != 0) ? 1'b0 : ~last_q;
    end
  end

  // While an address is stalled on the bus the grant is frozen at last cycle's value.
  assign grant    = lock_q ? gnt_q : grant_comb;
  assign gnt_req  = req[grant];
  assign addr_acc = gnt_req & s_hready;
  assign sel_m1   = grant & req[1];

  assign s_htrans = gnt_req ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign s_haddr  = sel_m1 ? m1_haddr  : m0_haddr;
  assign s_hwrite = sel_m1 ? m1_hwrite : m0_hwrite;
  assign s_hsize  = sel_m1 ? m1_hsize  : m0_hsize;
  assign s_hprot  = sel_m1 ? m1_hprot  : m0_hprot;
  assign s_hburst = sel_m1 ? m1_hburst : m0_hburst;
  assign s_hwdata = downer_q ? m1_hwdata : m0_hwdata;

  assign lock_d   = s_hready ? 1'b0 : (gnt_req | lock_q);
  assign last_d   = addr_acc ? grant : last_q;
  assign dvalid_d = s_hready ? addr_acc : dvalid_q;
  assign downer_d = s_hready ? grant : downer_q;

  // Per-master ready: a master with a pending data phase (on the bus or parked) gets ready only
  // when that phase is done AND its new address (if any) is taken in the same cycle. If the bus
  // completes its data phase while its next address is refused, the response is parked.
  always_comb begin
    for (int x = 0; x < 2; x++) begin
      dph[x]          = dvalid_q && (downer_q == 1'(x));
      bus_done[x]     = dph[x] && s_hready;
      aok[x]          = !req[x] || ((grant == 1'(x)) && s_hready);
      hready[x]       = (dph[x] || hold_v_q[x]) ? ((bus_done[x] || hold_v_q[x]) && aok[x]) : aok[x];
      hold_v_d[x]     = hold_v_q[x];
      hold_rdata_d[x] = hold_rdata_q[x];
      hold_resp_d[x]  = hold_resp_q[x];
      if (hready[x]) begin
        hold_v_d[x] = 1'b0;
      end else if (bus_done[x] && !aok[x]) begin
        hold_v_d[x]     = 1'b1;
        hold_rdata_d[x] = s_hrdata;
        hold_resp_d[x]  = s_hresp;
      end
    end
  end

  assign m0_hready = hready[0];
  assign m1_hready = hready[1];
  assign m0_hrdata = hold_v_q[0] ? hold_rdata_q[0] : (!downer_q ? s_hrdata : '0);
  assign m1_hrdata = hold_v_q[1] ? hold_rdata_q[1] : ( downer_q ? s_hrdata : '0);
  assign m0_hresp  = hold_v_q[0] ? hold_resp_q[0]  : (!downer_q & s_hresp);
  assign m1_hresp  = hold_v_q[1] ? hold_resp_q[1]  : ( downer_q & s_hresp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q       <= 1'b0;
      gnt_q        <= 1'b0;
      last_q       <= 1'b1;  // M0 wins the first tie
      dvalid_q     <= 1'b0;
      downer_q     <= 1'b0;
      hold_v_q     <= '0;
      hold_rdata_q <= '0;
      hold_resp_q  <= '0;
    end else begin
      lock_q       <= lock_d;
      gnt_q        <= grant;
      last_q       <= last_d;
      dvalid_q     <= dvalid_d;
      downer_q     <= downer_d;
      hold_v_q     <= hold_v_d;
      hold_rdata_q <= hold_rdata_d;
      hold_resp_q  <= hold_resp_d;
    end
  end

endmodule

// File: tb/tb_scr1_ahb_arb2.sv
module tb_scr1_ahb_arb2;
  localparam logic [1:0]  IDLE   = 2'b00;
  localparam logic [1:0]  NONSEQ = 2'b10;
  localparam logic [31:0] K      = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  m0_htrans, m1_htrans;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic [1:0]  s_htrans;
  logic [31:0] s_haddr, s_hwdata;
  logic        s_hwrite;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic        s_hready, s_hresp;
  logic [31:0] s_hrdata, sl_rdata;
  // fixed-priority instance outputs
  logic        f_m0_hready, f_m1_hready, f_m0_hresp, f_m1_hresp;
  logic [31:0] f_m0_hrdata, f_m1_hrdata, f_s_haddr, f_s_hwdata;
  logic [1:0]  f_s_htrans;
  logic        f_s_hwrite;
  logic [2:0]  f_s_hsize, f_s_hburst;
  logic [3:0]  f_s_hprot;

  always #5 clk = ~clk;

  scr1_ahb_arb2 #(.ARB_FIXED(0), .AHB_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_htrans(m0_htrans), .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
    .m0_hprot(m0_hprot), .m0_hburst(m0_hburst), .m0_hwdata(m0_hwdata),
    .m0_hready(m0_hready), .m0_hrdata(m0_hrdata), .m0_hresp(m0_hresp),
    .m1_htrans(m1_htrans), .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
    .m1_hprot(m1_hprot), .m1_hburst(m1_hburst), .m1_hwdata(m1_hwdata),
    .m1_hready(m1_hready), .m1_hrdata(m1_hrdata), .m1_hresp(m1_hresp),
    .s_htrans(s_htrans), .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
    .s_hprot(s_hprot), .s_hburst(s_hburst), .s_hwdata(s_hwdata),
    .s_hready(s_hready), .s_hrdata(s_hrdata), .s_hresp(s_hresp)
  );

  scr1_ahb_arb2 #(.ARB_FIXED(1), .AHB_W(32)) dut_fix (
    .clk(clk), .rst_n(rst_n),
    .m0_htrans(m0_htrans), .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
    .m0_hprot(m0_hprot), .m0_hburst(m0_hburst), .m0_hwdata(m0_hwdata),
    .m0_hready(f_m0_hready), .m0_hrdata(f_m0_hrdata), .m0_hresp(f_m0_hresp),
    .m1_htrans(m1_htrans), .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
    .m1_hprot(m1_hprot), .m1_hburst(m1_hburst), .m1_hwdata(m1_hwdata),
    .m1_hready(f_m1_hready), .m1_hrdata(f_m1_hrdata), .m1_hresp(f_m1_hresp),
    .s_htrans(f_s_htrans), .s_haddr(f_s_haddr), .s_hwrite(f_s_hwrite), .s_hsize(f_s_hsize),
    .s_hprot(f_s_hprot), .s_hburst(f_s_hburst), .s_hwdata(f_s_hwdata),
    .s_hready(s_hready), .s_hrdata(s_hrdata), .s_hresp(s_hresp)
  );

  // Slave model: read data for an accepted address appears in its data phase.
  assign s_hrdata = sl_rdata;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sl_rdata <= '0;
    else if (s_htrans == NONSEQ && s_hready)
      sl_rdata <= (s_haddr == 32'h2000) ? 32'hDEADBEEF : (s_haddr ^ K);
  end

  task automatic idle_masters;
    m0_htrans = IDLE; m0_haddr = '0; m0_hwrite = 1'b0; m0_hsize = 3'b010;
    m0_hprot = 4'b0011; m0_hburst = 3'b000; m0_hwdata = '0;
    m1_htrans = IDLE; m1_haddr = '0; m1_hwrite = 1'b0; m1_hsize = 3'b010;
    m1_hprot = 4'b0011; m1_hburst = 3'b000; m1_hwdata = '0;
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0; idle_masters(); s_hready = 1'b1; s_hresp = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    idle_masters(); s_hready = 1'b1; s_hresp = 1'b0;
    @(negedge clk);
    n_tests++; if (s_htrans !== IDLE) begin n_fail++; $display("FAIL reset_htrans: got %0h want %0h", s_htrans, IDLE); end
    n_tests++; if (m0_hready !== 1'b1) begin n_fail++; $display("FAIL reset_m0_hready: got %b want 1", m0_hready); end
    n_tests++; if (m1_hready !== 1'b1) begin n_fail++; $display("FAIL reset_m1_hready: got %b want 1", m1_hready); end
    n_tests++; if (dut.last_q !== 1'b1) begin n_fail++; $display("FAIL reset_last: got %b want 1", dut.last_q); end
    n_tests++; if (dut.lock_q !== 1'b0 || dut.dvalid_q !== 1'b0 || dut.hold_v_q !== 2'b00) begin
      n_fail++; $display("FAIL reset_state: lock %b dvalid %b hold %b want 0 0 00", dut.lock_q, dut.dvalid_q, dut.hold_v_q); end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_single_write;
    logic [31:0] wq[$];
    logic [31:0] e;
    apply_reset();
    m0_htrans = NONSEQ; m0_haddr = 32'h1000; m0_hwrite = 1'b1;
    wq.push_back(32'hA5A5A5A5);
    @(negedge clk);
    n_tests++; if (s_htrans !== NONSEQ || s_haddr !== 32'h1000) begin n_fail++; $display("FAIL wr_addr: got %0h/%h want 2/00001000", s_htrans, s_haddr); end
    n_tests++; if (s_hwrite !== 1'b1) begin n_fail++; $display("FAIL wr_hwrite: got %b want 1", s_hwrite); end
    n_tests++; if (m0_hready !== 1'b1 || m1_hready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_a: got %b%b want 11", m0_hready, m1_hready); end
    next_cycle();
    idle_masters(); m0_hwdata = 32'hA5A5A5A5;
    @(negedge clk);
    e = wq.pop_front();
    n_tests++; if (s_hwdata !== e) begin n_fail++; $display("FAIL wr_hwdata: got %h want %h", s_hwdata, e); end
    n_tests++; if (m0_hready !== 1'b1 || m1_hready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_d: got %b%b want 11", m0_hready, m1_hready); end
    n_tests++; if (s_htrans !== IDLE) begin n_fail++; $display("FAIL wr_idle: got %0h want 0", s_htrans); end
    next_cycle();
    idle_masters();
  endtask

  // Both masters stream 8 reads each; the bus must alternate M0, M1, ... and each master must
  // receive its own read data on the ready that completes each data phase.
  task automatic test_rr;
    logic [31:0] exp_a[$], rdq0[$], rdq1[$];
    logic [31:0] e;
    int i0, i1, pu0, pu1;
    bit p0, p1;
    apply_reset();
    for (int k = 0; k < 8; k++) begin exp_a.push_back(32'h100 + k); exp_a.push_back(32'h200 + k); end
    i0 = 0; i1 = 0; pu0 = 0; pu1 = 0; p0 = 1'b0; p1 = 1'b0;
    for (int n = 0; n < 40 && (exp_a.size() > 0 || p0 || p1); n++) begin
      if (i0 < 8) begin
        m0_htrans = NONSEQ; m0_haddr = 32'h100 + i0;
        if (pu0 == i0) begin rdq0.push_back((32'h100 + i0) ^ K); pu0++; end
      end else m0_htrans = IDLE;
      if (i1 < 8) begin
        m1_htrans = NONSEQ; m1_haddr = 32'h200 + i1;
        if (pu1 == i1) begin rdq1.push_back((32'h200 + i1) ^ K); pu1++; end
      end else m1_htrans = IDLE;
      @(negedge clk);
      if (s_htrans == NONSEQ && s_hready) begin
        e = (exp_a.size() > 0) ? exp_a.pop_front() : 32'hFFFF_FFFF;
        n_tests++; if (s_haddr !== e) begin n_fail++; $display("FAIL rr_order: got %h want %h", s_haddr, e); end
      end
      if (m0_hready) begin
        if (p0) begin
          e = (rdq0.size() > 0) ? rdq0.pop_front() : 32'hFFFF_FFFF;
          n_tests++; if (m0_hrdata !== e) begin n_fail++; $display("FAIL rr_m0_rdata: got %h want %h", m0_hrdata, e); end
        end
        p0 = (m0_htrans == NONSEQ);
        if (p0) i0++;
      end
      if (m1_hready) begin
        if (p1) begin
          e = (rdq1.size() > 0) ? rdq1.pop_front() : 32'hFFFF_FFFF;
          n_tests++; if (m1_hrdata !== e) begin n_fail++; $display("FAIL rr_m1_rdata: got %h want %h", m1_hrdata, e); end
        end
        p1 = (m1_htrans == NONSEQ);
        if (p1) i1++;
      end
      next_cycle();
    end
    n_tests++; if (exp_a.size() != 0 || p0 || p1) begin n_fail++; $display("FAIL rr_timeout: left %0d pend %b%b want 0 00", exp_a.size(), p0, p1); end
    idle_masters();
  endtask

  // Fixed priority: M1 requests every cycle, M0 follows a pattern; M1 may only win when M0 is idle.
  task automatic test_fixed;
    logic [31:0] exp_a[$];
    logic [31:0] e;
    logic [7:0] pat;
    pat = 8'b0110_1101;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      m1_htrans = NONSEQ; m1_haddr = 32'h5000;
      m0_htrans = pat[i] ? NONSEQ : IDLE; m0_haddr = 32'h4000 + i;
      exp_a.push_back(pat[i] ? (32'h4000 + i) : 32'h5000);
      @(negedge clk);
      e = exp_a.pop_front();
      n_tests++; if (f_s_htrans !== NONSEQ || f_s_haddr !== e) begin n_fail++; $display("FAIL fix_grant%0d: got %0h/%h want 2/%h", i, f_s_htrans, f_s_haddr, e); end
      n_tests++; if (f_m1_hready !== !pat[i]) begin n_fail++; $display("FAIL fix_m1_rdy%0d: got %b want %b", i, f_m1_hready, !pat[i]); end
      next_cycle();
    end
    idle_masters();
  endtask

  task automatic test_hold;
    logic [31:0] rdq1[$];
    logic [31:0] e;
    apply_reset();
    m1_htrans = NONSEQ; m1_haddr = 32'h2000; rdq1.push_back(32'hDEADBEEF);
    @(negedge clk);
    n_tests++; if (s_haddr !== 32'h2000 || m1_hready !== 1'b1) begin n_fail++; $display("FAIL hold_a: got %h/%b want 00002000/1", s_haddr, m1_hready); end
    next_cycle();
    m1_haddr = 32'h2004; rdq1.push_back(32'h2004 ^ K);
    m0_htrans = NONSEQ; m0_haddr = 32'h3000;
    @(negedge clk);
    n_tests++; if (s_haddr !== 32'h3000 || m1_hready !== 1'b0) begin n_fail++; $display("FAIL hold_b: got %h/%b want 00003000/0", s_haddr, m1_hready); end
    next_cycle();
    m0_htrans = IDLE;
    @(negedge clk);
    n_tests++; if (dut.hold_v_q[1] !== 1'b1) begin n_fail++; $display("FAIL hold_v1: got %b want 1", dut.hold_v_q[1]); end
    n_tests++; if (m1_hready !== 1'b1 || s_haddr !== 32'h2004) begin n_fail++; $display("FAIL hold_c: got %b/%h want 1/00002004", m1_hready, s_haddr); end
    e = rdq1.pop_front();
    n_tests++; if (m1_hrdata !== e) begin n_fail++; $display("FAIL hold_rdata: got %h want %h", m1_hrdata, e); end
    next_cycle();
    idle_masters();
    @(negedge clk);
    e = rdq1.pop_front();
    n_tests++; if (m1_hready !== 1'b1 || m1_hrdata !== e) begin n_fail++; $display("FAIL hold_d: got %b/%h want 1/%h", m1_hready, m1_hrdata, e); end
    n_tests++; if (dut.hold_v_q !== 2'b00) begin n_fail++; $display("FAIL hold_clear: got %b want 00", dut.hold_v_q); end
    next_cycle();
  endtask

  // Three wait states with M1's address on the bus while M0 starts requesting.
  task automatic test_lock;
    logic        r0[6], r1[6], rdy[6], elk[6], e0[6], e1[6];
    logic [31:0] a1[6];
    logic [31:0] exp_a[$];
    logic [31:0] e;
    r0  = '{0, 0, 1, 1, 1, 1};
    r1  = '{1, 1, 1, 1, 1, 0};
    a1  = '{32'h6100, 32'h6000, 32'h6000, 32'h6000, 32'h6000, 32'h0};
    rdy = '{1, 0, 0, 0, 1, 1};
    elk = '{0, 0, 1, 1, 1, 0};
    e0  = '{1, 1, 0, 0, 0, 1};
    e1  = '{1, 0, 0, 0, 1, 1};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      m0_htrans = r0[i] ? NONSEQ : IDLE; m0_haddr = 32'h7000;
      m1_htrans = r1[i] ? NONSEQ : IDLE; m1_haddr = a1[i];
      s_hready = rdy[i];
      exp_a.push_back(r1[i] ? a1[i] : 32'h7000);
      @(negedge clk);
      e = exp_a.pop_front();
      n_tests++; if (s_htrans !== NONSEQ || s_haddr !== e) begin n_fail++; $display("FAIL lock_addr%0d: got %0h/%h want 2/%h", i, s_htrans, s_haddr, e); end
      n_tests++; if (dut.lock_q !== elk[i]) begin n_fail++; $display("FAIL lock_q%0d: got %b want %b", i, dut.lock_q, elk[i]); end
      n_tests++; if (m0_hready !== e0[i] || m1_hready !== e1[i]) begin n_fail++; $display("FAIL lock_rdy%0d: got %b%b want %b%b", i, m0_hready, m1_hready, e0[i], e1[i]); end
      next_cycle();
    end
    idle_masters(); s_hready = 1'b1;
  endtask

  task automatic test_error_reset;
    apply_reset();
    m0_htrans = NONSEQ; m0_haddr = 32'h8000;
    next_cycle();
    idle_masters(); s_hready = 1'b0; s_hresp = 1'b1;
    @(negedge clk);
    n_tests++; if (m0_hresp !== 1'b1 || m0_hready !== 1'b0) begin n_fail++; $display("FAIL err_c1_m0: got resp %b rdy %b want 1 0", m0_hresp, m0_hready); end
    n_tests++; if (m1_hresp !== 1'b0 || m1_hready !== 1'b1) begin n_fail++; $display("FAIL err_c1_m1: got resp %b rdy %b want 0 1", m1_hresp, m1_hready); end
    next_cycle();
    s_hready = 1'b1;
    @(negedge clk);
    n_tests++; if (m0_hresp !== 1'b1 || m0_hready !== 1'b1) begin n_fail++; $display("FAIL err_c2_m0: got resp %b rdy %b want 1 1", m0_hresp, m0_hready); end
    n_tests++; if (m1_hresp !== 1'b0 || m1_hready !== 1'b1) begin n_fail++; $display("FAIL err_c2_m1: got resp %b rdy %b want 0 1", m1_hresp, m1_hready); end
    next_cycle();
    s_hresp = 1'b0; m1_htrans = NONSEQ; m1_haddr = 32'h9000;
    next_cycle();
    m1_haddr = 32'h9100; s_hready = 1'b0;
    next_cycle();
    @(negedge clk);
    n_tests++; if (dut.lock_q !== 1'b1 || dut.dvalid_q !== 1'b1 || m1_hready !== 1'b0) begin
      n_fail++; $display("FAIL stall_state: lock %b dvalid %b m1rdy %b want 1 1 0", dut.lock_q, dut.dvalid_q, m1_hready); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (dut.lock_q !== 1'b0 || dut.dvalid_q !== 1'b0 || dut.downer_q !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: lock %b dvalid %b downer %b want 0 0 0", dut.lock_q, dut.dvalid_q, dut.downer_q); end
    n_tests++; if (dut.last_q !== 1'b1 || dut.hold_v_q !== 2'b00) begin n_fail++; $display("FAIL rst_mid_last: last %b hold %b want 1 00", dut.last_q, dut.hold_v_q); end
    n_tests++; if (m0_hready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_m0rdy: got %b want 1", m0_hready); end
    idle_masters(); s_hready = 1'b1;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    idle_masters();
    s_hready = 1'b1;
    s_hresp  = 1'b0;
    test_reset();
    test_single_write();
    test_rr();
    test_fixed();
    test_hold();
    test_lock();
    test_error_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
